div_seq_unit: RTL

//  Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.

---
 rtl/mdu_pkg.sv | 13 +
 rtl/adder32.sv | 12 +
 rtl/div_seq_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_e;
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;

    localparam int DIV_ITERS = 32;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/adder32.sv
// adder32: 32-bit adder with carry in/out, used as the divider's trial subtractor.
module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'd0, c_in};

endmodule

// File: rtl/div_seq_unit.sv
// div_seq_unit: radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// DIV_EARLY_OUT_EN: divide-by-zero and signed overflow bypass the iteration.
module div_seq_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    input  logic            i_flush,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_result
);

    div_state_e  state;
    div_op_e     op;
    logic [31:0] dd, ds, raw, q, sum, q_fin, r_fin;
    logic [32:0] p, ps;
    logic [4:0]  cnt;
    logic        sa, sb, dz, ovf, c_out, ok, sg, in_sa, in_sb, in_dz, in_ovf;

    assign sg     = ~i_op[0];
    assign in_sa  = sg & i_dividend[31];
    assign in_sb  = sg & i_divisor[31];
    assign in_dz  = i_divisor == 32'd0;
    assign in_ovf = sg && i_dividend == 32'h8000_0000 && i_divisor == 32'hFFFF_FFFF;

    assign ps = {p[31:0], dd[31]};
    assign ok = ps[32] | c_out;

    // Subtract by adding the complement with carry-in; carry-out means no borrow.
    adder32 u_sub (
        .a    (ps[31:0]),
        .b    (~ds),
        .c_in (1'b1),
        .sum  (sum),
        .c_out(c_out)
    );

    assign q_fin = dz ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : (sa ^ sb) ? neg32(q) : q;
    assign r_fin = dz ? raw : ovf ? 32'd0 : sa ? neg32(p[31:0]) : p[31:0];
    assign o_in_ready = state == IDLE;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            op          <= DIV;
            dd          <= '0;
            ds          <= '0;
            raw         <= '0;
            q           <= '0;
            p           <= '0;
            cnt         <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            dz          <= 1'b0;
            ovf         <= 1'b0;
            o_out_valid <= 1'b0;
            o_result    <= '0;
        end else if (i_flush) begin
            state       <= IDLE;
            o_out_valid <= 1'b0;
            o_result    <= '0;
        end else begin
            case (state)
                IDLE: if (i_in_valid) begin
                    op  <= div_op_e'(i_op);
                    sa  <= in_sa;
                    sb  <= in_sb;
                    dz  <= in_dz;
                    ovf <= in_ovf;
                    raw <= i_dividend;
                    dd  <= in_sa ? neg32(i_dividend) : i_dividend;
                    ds  <= in_sb ? neg32(i_divisor) : i_divisor;
                    p   <= '0;
                    q   <= '0;
                    cnt <= '0;
`ifdef DIV_EARLY_OUT_EN
                    state <= (in_dz | in_ovf) ? DONE : CALC;
`else
                    state <= CALC;
`endif
                end
                CALC: begin
                    dd    <= dd << 1;
                    p     <= ok ? {1'b0, sum} : ps;
                    q     <= {q[30:0], ok};
                    cnt   <= cnt + 5'd1;
                    state <= cnt == 5'(DIV_ITERS - 1) ? DONE : CALC;
                end
                DONE: if (!o_out_valid) begin
                    o_out_valid <= 1'b1;
                    o_result    <= op[1] ? r_fin : q_fin;
                end else if (i_out_ready) begin
                    state       <= IDLE;
                    o_out_valid <= 1'b0;
                    o_result    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
